// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_BITS   = 512;
  localparam int OFFSET_BITS = 6;
  localparam int WORD_BITS   = 32;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_e;

  function automatic logic [WORD_BITS-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                     input logic [3:0] w);
    return line[{w, 5'b00000} +: WORD_BITS];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Data/tag/valid storage: one write port, one asynchronous read port, and a
// clear-all of the valid bits that takes priority over a concurrent write.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = 6,
  parameter int TAG_W     = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     widx_i,
  input  logic [TAG_W-1:0]     wtag_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  input  logic [IDX_W-1:0]     ridx_i,
  output logic                 rvalid_o,
  output logic [TAG_W-1:0]     rtag_o,
  output logic [LINE_BITS-1:0] rdata_o
);

  logic [NUM_LINES-1:0] valid_q;
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];

  // Valid bits: invalidate-all beats a fill landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {NUM_LINES{1'b0}};
    end else if (clr_i) begin
      valid_q <= {NUM_LINES{1'b0}};
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Payload storage is not reset; the valid bit guards it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[widx_i] <= wdata_i;
      tag_q[widx_i]  <= wtag_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with a mem_ctrl read-only host port.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module instr_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr,
  input  logic                 en,
  input  logic                 inv,
  output logic [31:0]          data_out,
  output logic                 done,
  output logic                 stall,
  input  logic [LINE_BITS-1:0] DataIn_host,
  input  logic                 tx_done_host,
  input  logic                 rd_valid_host,
  output logic [LINE_BITS-1:0] DataOut_host,
  output logic [31:0]          AddrOut_host,
  output logic [1:0]           op_host
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - OFFSET_BITS - IDX_W;
  localparam int LADR_W = 32 - OFFSET_BITS;

  state_e              state_q, state_d;
  logic [LADR_W-1:0]   miss_q, miss_d;

  logic [IDX_W-1:0]     lk_idx_s;
  logic [TAG_W-1:0]     lk_tag_s;
  logic                 rd_valid_s;
  logic [TAG_W-1:0]     rd_tag_s;
  logic [LINE_BITS-1:0] rd_line_s;
  logic                 hit_s;
  logic                 miss_s;
  logic                 fill_s;
  logic                 unused_s;

  assign lk_idx_s = addr[OFFSET_BITS +: IDX_W];
  assign lk_tag_s = addr[31 -: TAG_W];
  assign unused_s = ^addr[1:0];

  assign hit_s  = (state_q == S_IDLE) && en && rd_valid_s && (rd_tag_s == lk_tag_s);
  assign miss_s = (state_q == S_IDLE) && en && !hit_s;
  assign fill_s = ((state_q == S_REQ) || (state_q == S_WAIT)) && rd_valid_host;

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (inv),
    .we_i     (fill_s),
    .widx_i   (miss_q[IDX_W-1:0]),
    .wtag_i   (miss_q[LADR_W-1 -: TAG_W]),
    .wdata_i  (DataIn_host),
    .ridx_i   (lk_idx_s),
    .rvalid_o (rd_valid_s),
    .rtag_o   (rd_tag_s),
    .rdata_o  (rd_line_s)
  );

  // State and miss-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      miss_q  <= {LADR_W{1'b0}};
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  // Next state: the fill always targets the latched line, whatever addr does meanwhile.
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    case (state_q)
      S_IDLE: begin
        if (miss_s) begin
          miss_d  = addr[31:OFFSET_BITS];
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (rd_valid_host) begin
          state_d = S_IDLE;
        end else if (tx_done_host) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (rd_valid_host) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode; rst_n gating keeps done/stall low while reset is held.
  always_comb begin
    done         = rst_n & hit_s;
    stall        = rst_n & (miss_s | (state_q != S_IDLE));
    DataOut_host = {LINE_BITS{1'b0}};
    if (done) begin
      data_out = line_word(rd_line_s, addr[5:2]);
    end else begin
      data_out = 32'h0000_0000;
    end
    if (state_q == S_REQ) begin
      op_host      = OP_READ;
      AddrOut_host = {miss_q, {OFFSET_BITS{1'b0}}};
    end else begin
      op_host      = OP_NONE;
      AddrOut_host = 32'h0000_0000;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters; a miss is counted on the IDLE->REQ transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit_s) begin
        hit_count <= sat_inc(hit_count);
      end
      if (miss_s) begin
        miss_count <= sat_inc(miss_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus randomized
// fetch streams checked against a direct-mapped cache model.
module tb_instr_cache;
  import icache_pkg::*;

  localparam int NL = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  addr = 32'd0;
  logic         en = 1'b0;
  logic         inv = 1'b0;
  logic [31:0]  data_out;
  logic         done;
  logic         stall;
  logic [511:0] DataIn_host = 512'd0;
  logic         tx_done_host = 1'b0;
  logic         rd_valid_host = 1'b0;
  logic [511:0] DataOut_host;
  logic [31:0]  AddrOut_host;
  logic [1:0]   op_host;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model: for each line slot, which memory line it holds and its data.
  logic [511:0] m_data  [NL];
  logic [25:0]  m_line  [NL];
  bit           m_valid [NL];

  instr_cache #(.NUM_LINES(NL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr          (addr),
    .en            (en),
    .inv           (inv),
    .data_out      (data_out),
    .done          (done),
    .stall         (stall),
    .DataIn_host   (DataIn_host),
    .tx_done_host  (tx_done_host),
    .rd_valid_host (rd_valid_host),
    .DataOut_host  (DataOut_host),
    .AddrOut_host  (AddrOut_host),
    .op_host       (op_host)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 6) % NL);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int i;
    i = m_idx(a);
    return m_valid[i] && (m_line[i] == a[31:6]);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [511:0] l;
    int w;
    l = m_data[m_idx(a)];
    w = int'(a[5:2]);
    return l[32*w +: 32];
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Expected {done, stall, op, AddrOut, data_out, DataOut_host==0}.
  function automatic logic [68:0] expv(input logic d, input logic s, input logic [1:0] op,
                                       input logic [31:0] ad, input logic [31:0] dat);
    return {d, s, op, ad, dat, 1'b1};
  endfunction

  function automatic logic [68:0] obsv();
    return {done, stall, op_host, AddrOut_host, data_out, DataOut_host == 512'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch from IDLE: lookup, and on a miss drive the host handshake with the
  // given latencies; returns at posedge+1 with the cache back in IDLE.
  task automatic fetch(input logic [31:0] a, input logic [511:0] fill, input int req_n,
                       input bit comb, input int wait_n, input bit inv_f, input string nm);
    logic [68:0] e, o;
    bit hit;
    addr = a;
    en   = 1'b1;
    @(negedge clk);
    hit = m_hit(a);
    e = hit ? expv(1'b1, 1'b0, 2'b00, 32'd0, m_word(a)) : expv(1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
    o = obsv();
    total++;
    if (o !== e) $display("FAIL %s lookup a=%h: got %h expected %h", nm, a, o, e);
    else passed++;
    step();
    if (hit) return;
    for (int c = 0; c <= req_n; c++) begin
      tx_done_host  = (c == req_n);
      rd_valid_host = comb && (c == req_n);
      inv           = inv_f && rd_valid_host;
      DataIn_host   = rd_valid_host ? fill : rand_line();
      @(negedge clk);
      e = expv(1'b0, 1'b1, 2'b01, {a[31:6], 6'd0}, 32'd0);
      o = obsv();
      total++;
      if (o !== e) $display("FAIL %s req a=%h: got %h expected %h", nm, a, o, e);
      else passed++;
      step();
    end
    tx_done_host = 1'b0;
    if (!comb) begin
      for (int c = 0; c <= wait_n; c++) begin
        rd_valid_host = (c == wait_n);
        inv           = inv_f && rd_valid_host;
        DataIn_host   = rd_valid_host ? fill : rand_line();
        @(negedge clk);
        e = expv(1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
        o = obsv();
        total++;
        if (o !== e) $display("FAIL %s wait a=%h: got %h expected %h", nm, a, o, e);
        else passed++;
        step();
      end
    end
    rd_valid_host = 1'b0;
    inv           = 1'b0;
    if (inv_f) begin
      m_clear();
    end else begin
      m_data[m_idx(a)]  = fill;
      m_line[m_idx(a)]  = a[31:6];
      m_valid[m_idx(a)] = 1'b1;
    end
  endtask

  // One cycle with en=0, optional host strobes and invalidate; cache must stay quiet.
  task automatic idle_cycle(input bit rv, input bit td, input bit iv, input string nm);
    logic [68:0] e, o;
    en            = 1'b0;
    rd_valid_host = rv;
    tx_done_host  = td;
    inv           = iv;
    DataIn_host   = rand_line();
    @(negedge clk);
    e = expv(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    o = obsv();
    total++;
    if (o !== e) $display("FAIL %s idle: got %h expected %h", nm, o, e);
    else passed++;
    step();
    if (iv) m_clear();
    rd_valid_host = 1'b0;
    tx_done_host  = 1'b0;
    inv           = 1'b0;
  endtask

  task automatic test_reset();
    logic [68:0] e, o;
    m_clear();
    rst_n = 1'b0;
    en    = 1'b1;
    addr  = 32'h0000_0104;
    @(negedge clk);
    e = expv(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    o = obsv();
    total++;
    if (o !== e) $display("FAIL reset_held: got %h expected %h", o, e);
    else passed++;
    step();
    rst_n = 1'b1;
    en    = 1'b0;
    step();
    idle_cycle(1'b0, 1'b0, 1'b0, "reset_release");
  endtask

  task automatic test_cold_miss_and_hit();
    logic [511:0] l;
    l = rand_line();
    l[63:32] = 32'hDEAD_BEEF;
    fetch(32'h0000_0104, l, 1, 1'b0, 0, 1'b0, "cold_miss");
    fetch(32'h0000_0104, rand_line(), 0, 1'b0, 0, 1'b0, "cold_fill_hit");
    fetch(32'h0000_013C, rand_line(), 0, 1'b0, 0, 1'b0, "hit_word15");
  endtask

  task automatic test_conflict();
    fetch(32'h0000_1100, rand_line(), 2, 1'b0, 1, 1'b0, "conflict_new_tag");
    fetch(32'h0000_0100, rand_line(), 0, 1'b1, 0, 1'b0, "conflict_old_tag");
    fetch(32'h0000_0108, rand_line(), 0, 1'b0, 0, 1'b0, "conflict_refill_hit");
  endtask

  task automatic test_addr_change();
    logic [68:0] e, o;
    logic [511:0] l;
    l = rand_line();
    addr = 32'h0000_0200;
    en   = 1'b1;
    @(negedge clk);
    e = expv(1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
    o = obsv();
    total++;
    if (o !== e) $display("FAIL chg_lookup: got %h expected %h", o, e);
    else passed++;
    step();
    tx_done_host = 1'b1;
    @(negedge clk);
    e = expv(1'b0, 1'b1, 2'b01, 32'h0000_0200, 32'd0);
    o = obsv();
    total++;
    if (o !== e) $display("FAIL chg_req: got %h expected %h", o, e);
    else passed++;
    step();
    tx_done_host = 1'b0;
    addr = 32'h0000_0400;
    for (int c = 0; c < 2; c++) begin
      rd_valid_host = (c == 1);
      DataIn_host   = rd_valid_host ? l : rand_line();
      @(negedge clk);
      e = expv(1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
      o = obsv();
      total++;
      if (o !== e) $display("FAIL chg_wait: got %h expected %h", o, e);
      else passed++;
      step();
    end
    rd_valid_host = 1'b0;
    m_data[m_idx(32'h200)]  = l;
    m_line[m_idx(32'h200)]  = 26'h8;
    m_valid[m_idx(32'h200)] = 1'b1;
    fetch(32'h0000_0400, rand_line(), 0, 1'b0, 2, 1'b0, "chg_new_miss");
    fetch(32'h0000_0204, rand_line(), 0, 1'b0, 0, 1'b0, "chg_old_filled");
  endtask

  task automatic test_inv_coincident();
    fetch(32'h0000_0600, rand_line(), 0, 1'b0, 1, 1'b1, "inv_fill");
    fetch(32'h0000_0600, rand_line(), 1, 1'b1, 0, 1'b0, "inv_refetch");
    fetch(32'h0000_0104, rand_line(), 0, 1'b0, 0, 1'b0, "inv_cleared_other");
    fetch(32'h0000_0600, rand_line(), 0, 1'b0, 0, 1'b0, "inv_then_hit");
  endtask

  task automatic test_reset_mid_fill();
    logic [68:0] e, o;
    addr = 32'h0000_0800;
    en   = 1'b1;
    step();
    tx_done_host = 1'b1;
    step();
    tx_done_host = 1'b0;
    rst_n = 1'b0;
    m_clear();
    #1;
    e = expv(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    o = obsv();
    total++;
    if (o !== e) $display("FAIL rst_wait_immediate: got %h expected %h", o, e);
    else passed++;
    step();
    rst_n = 1'b1;
    idle_cycle(1'b1, 1'b0, 1'b0, "rst_late_rdvalid");
    idle_cycle(1'b1, 1'b1, 1'b0, "rst_late_both");
    fetch(32'h0000_0800, rand_line(), 0, 1'b0, 0, 1'b0, "rst_next_miss");
    fetch(32'h0000_0800, rand_line(), 0, 1'b0, 0, 1'b0, "rst_next_hit");
  endtask

  task automatic test_top_line();
    fetch(32'hFFFF_FFC0, rand_line(), 0, 1'b0, 0, 1'b0, "top_miss");
    fetch(32'hFFFF_FFFC, rand_line(), 0, 1'b0, 0, 1'b0, "top_hit_w15");
  endtask

  task automatic test_random();
    logic [19:0] tags [4];
    logic [31:0] a;
    tags[0] = 20'h00000;
    tags[1] = 20'h00001;
    tags[2] = 20'hFFFFF;
    tags[3] = 20'hABCDE;
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), "rnd_idle");
      end else begin
        a = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 7)),
             4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        fetch(a, rand_line(), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), ($urandom_range(0, 11) == 0), "rnd_fetch");
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss_and_hit();
    test_conflict();
    test_addr_change();
    test_inv_coincident();
    test_reset_mid_fill();
    test_top_line();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
